// File: rtl/vga_capture_pkg.sv
// Shared constants, FSM state type and small helpers for the vga_capture monitor.
// The CRC helper is used only when VGA_CAPTURE_CRC_EN is defined.
package vga_capture_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int CELL_W   = 20;
   localparam int CELL_H   = 15;
   localparam int GRID     = 32;
   localparam int SAMPLE_X = 10;
   localparam int SAMPLE_Y = 7;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE
   } cap_state_e;

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   // One MSB-first CRC-16-CCITT step over a single data bit.
   function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Control/readback bus of vga_capture; frame_crc exists only when
// VGA_CAPTURE_CRC_EN is defined.
interface vga_capture_if;

   logic        arm;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic        busy;
   logic        frame_done;
   logic [15:0] frames;
   logic        line_err;
`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] frame_crc;
`endif

   modport master (
      output arm, rd_addr,
      input  rd_data, busy, frame_done, frames, line_err
`ifdef VGA_CAPTURE_CRC_EN
      , frame_crc
`endif
   );

   modport slave (
      input  arm, rd_addr,
      output rd_data, busy, frame_done, frames, line_err
`ifdef VGA_CAPTURE_CRC_EN
      , frame_crc
`endif
   );

endinterface

// File: rtl/capture_ram.sv
// 1024x1 simple dual-port cell memory: one write port, one registered read port,
// both on CLOCK_50.
module capture_ram (
   input  logic       CLOCK_50,
   input  logic       we_i,
   input  logic [9:0] waddr_i,
   input  logic       wdata_i,
   input  logic [9:0] raddr_i,
   output logic       rdata_o
);

   logic mem_q [0:1023];

   // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
   always_ff @(posedge CLOCK_50) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/vga_capture.sv
// Rebuilds the 32x32 character-cell screen from the VGA raster by sampling each
// cell centre into capture_ram. Optional frame CRC: define VGA_CAPTURE_CRC_EN.
module vga_capture #(
   parameter logic [15:0] BASE_ADDR = 16'h0200,
   parameter int          H_ACTIVE  = vga_capture_pkg::H_ACTIVE,
   parameter int          V_ACTIVE  = vga_capture_pkg::V_ACTIVE,
   parameter int          CELL_W    = vga_capture_pkg::CELL_W,
   parameter int          CELL_H    = vga_capture_pkg::CELL_H,
   parameter int          SAMPLE_X  = vga_capture_pkg::SAMPLE_X,
   parameter int          SAMPLE_Y  = vga_capture_pkg::SAMPLE_Y
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         VGA_CLK,
   input  logic         VGA_HS,
   input  logic         VGA_VS,
   input  logic         VGA_BLANK,
   input  logic [9:0]   VGA_R,
   input  logic [9:0]   VGA_G,
   input  logic [9:0]   VGA_B,
   vga_capture_if.slave bus
);
   import vga_capture_pkg::*;

   localparam logic [4:0] CX_LAST   = 5'(CELL_W - 1);
   localparam logic [4:0] CY_LAST   = 5'(CELL_H - 1);
   localparam logic [4:0] CX_SAMPLE = 5'(SAMPLE_X);
   localparam logic [4:0] CY_SAMPLE = 5'(SAMPLE_Y);
   localparam logic [4:0] CELL_LAST = 5'(GRID - 1);
   localparam logic [9:0] H_EXPECT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_EXPECT  = 10'(V_ACTIVE);

   cap_state_e  state_q, state_d;
   logic        vga_clk_q, blank_q, vs_q;
   logic [4:0]  cx_q, cx_d, col_q, col_d, cy_q, cy_d, row_q, row_d;
   logic [9:0]  px_cnt_q, px_cnt_d, ln_cnt_q, ln_cnt_d;
   logic        line_err_q, line_err_d;
   logic [15:0] frames_q, frames_d;
   logic        frame_done_q, frame_done_d;
   logic        we_q, we_d, wdata_q, wdata_d;
   logic [9:0]  waddr_q, waddr_d;
   logic        in_range_q, ram_rdata;
   logic [15:0] rd_off;
   logic        pix, active_pix, blank_fall, vs_fall;
   logic        unused_hs;

   assign unused_hs  = VGA_HS;
   assign pix        = VGA_CLK & ~vga_clk_q;
   assign active_pix = pix & VGA_BLANK;
   assign blank_fall = blank_q & ~VGA_BLANK;
   assign vs_fall    = vs_q & ~VGA_VS;

   // NOTE: every _d gets its default first, so no path leaves a latch behind.
   always_comb begin
      state_d      = state_q;
      cx_d         = cx_q;
      col_d        = col_q;
      cy_d         = cy_q;
      row_d        = row_q;
      px_cnt_d     = px_cnt_q;
      ln_cnt_d     = ln_cnt_q;
      line_err_d   = line_err_q;
      frames_d     = frames_q;
      frame_done_d = 1'b0;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;

      if (blank_fall) begin
         cx_d     = '0;
         col_d    = '0;
         px_cnt_d = '0;
      end else if (active_pix) begin
         px_cnt_d = sat_inc10(px_cnt_q);
         if (cx_q == CX_LAST) begin
            cx_d = '0;
            if (col_q != CELL_LAST) col_d = col_q + 5'd1;
         end else begin
            cx_d = cx_q + 5'd1;
         end
      end

      if (vs_fall) begin
         cy_d     = '0;
         row_d    = '0;
         ln_cnt_d = '0;
      end else if (blank_fall) begin
         ln_cnt_d = sat_inc10(ln_cnt_q);
         if (cy_q == CY_LAST) begin
            cy_d = '0;
            if (row_q != CELL_LAST) row_d = row_q + 5'd1;
         end else begin
            cy_d = cy_q + 5'd1;
         end
      end

      if (state_q == CAPTURE && active_pix && cx_q == CX_SAMPLE && cy_q == CY_SAMPLE) begin
         we_d    = 1'b1;
         waddr_d = {row_q, col_q};
         wdata_d = |{VGA_R, VGA_G, VGA_B};
      end

      case (state_q)
         IDLE: begin
            if (bus.arm) begin
               state_d    = ARMED;
               line_err_d = 1'b0;
            end
         end
         ARMED: begin
            if (vs_fall) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (blank_fall && px_cnt_q != H_EXPECT) line_err_d = 1'b1;
            if (vs_fall) begin
               if (ln_cnt_q != V_EXPECT) line_err_d = 1'b1;
               state_d      = IDLE;
               frame_done_d = 1'b1;
               frames_d     = frames_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Addresses below the window wrap to large offsets, so one upper-bit test covers both bounds.
   assign rd_off = bus.rd_addr - BASE_ADDR;

   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= IDLE;
         vga_clk_q    <= 1'b0;
         blank_q      <= 1'b0;
         vs_q         <= 1'b0;
         cx_q         <= '0;
         col_q        <= '0;
         cy_q         <= '0;
         row_q        <= '0;
         px_cnt_q     <= '0;
         ln_cnt_q     <= '0;
         line_err_q   <= 1'b0;
         frames_q     <= '0;
         frame_done_q <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= 1'b0;
         in_range_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         vga_clk_q    <= VGA_CLK;
         blank_q      <= VGA_BLANK;
         vs_q         <= VGA_VS;
         cx_q         <= cx_d;
         col_q        <= col_d;
         cy_q         <= cy_d;
         row_q        <= row_d;
         px_cnt_q     <= px_cnt_d;
         ln_cnt_q     <= ln_cnt_d;
         line_err_q   <= line_err_d;
         frames_q     <= frames_d;
         frame_done_q <= frame_done_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         in_range_q   <= (rd_off[15:10] == 6'd0);
      end
   end

   capture_ram u_ram (
      .CLOCK_50 (CLOCK_50),
      .we_i     (we_q),
      .waddr_i  (waddr_q),
      .wdata_i  (wdata_q),
      .raddr_i  (rd_off[9:0]),
      .rdata_o  (ram_rdata)
   );

   assign bus.rd_data    = in_range_q ? {7'd0, ram_rdata} : 8'h00;
   assign bus.busy       = (state_q != IDLE);
   assign bus.frame_done = frame_done_q;
   assign bus.frames     = frames_q;
   assign bus.line_err   = line_err_q;

`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] crc_q, crc_d, frame_crc_q;

   always_comb begin
      crc_d = crc_q;
      if (state_q == ARMED && vs_fall) crc_d = CRC_INIT;
      else if (we_q)                   crc_d = crc16_bit(crc_q, wdata_q);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         crc_q       <= '0;
         frame_crc_q <= '0;
      end else begin
         crc_q <= crc_d;
         if (frame_done_d) frame_crc_q <= crc_d;
      end
   end

   assign bus.frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a scaled raster (2x2-pixel cells, 64x64 active)
// with hand-computed readback tables; CRC checks run when VGA_CAPTURE_CRC_EN is defined.
module tb_vga_capture;

   localparam int CW = 2;
   localparam int CH = 2;
   localparam int SX = 1;
   localparam int SY = 1;
   localparam int HA = 32 * CW;
   localparam int VA = 32 * CH;

   localparam int M_DARK   = 0;
   localparam int M_SINGLE = 1;
   localparam int M_CHECK  = 2;
   localparam int M_ALL    = 3;

   typedef struct {
      int          phase;
      logic [15:0] addr;
      logic [7:0]  exp;
   } rd_vec_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK;
   logic [9:0] VGA_R, VGA_G, VGA_B;
   int         checks = 0;
   int         failures = 0;
   int         fd_count = 0;
   rd_vec_t    vecs [22];

   vga_capture_if bus ();

   vga_capture #(
      .BASE_ADDR (16'h0200),
      .H_ACTIVE  (HA),
      .V_ACTIVE  (VA),
      .CELL_W    (CW),
      .CELL_H    (CH),
      .SAMPLE_X  (SX),
      .SAMPLE_Y  (SY)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .VGA_CLK   (VGA_CLK),
      .VGA_HS    (VGA_HS),
      .VGA_VS    (VGA_VS),
      .VGA_BLANK (VGA_BLANK),
      .VGA_R     (VGA_R),
      .VGA_G     (VGA_G),
      .VGA_B     (VGA_B),
      .bus       (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) if (bus.frame_done === 1'b1) fd_count++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic vclk, input logic blank, input logic vs, input logic [29:0] rgb);
      @(negedge CLOCK_50);
      VGA_CLK   = vclk;
      VGA_BLANK = blank;
      VGA_VS    = vs;
      {VGA_R, VGA_G, VGA_B} = rgb;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b1, 30'h0);
   endtask

   task automatic pulse_arm();
      idle(1);
      bus.arm = 1'b1;
      idle(1);
      bus.arm = 1'b0;
   endtask

   task automatic vs_pulse(input bit arm_at_fall);
      idle(4);
      step(1'b0, 1'b0, 1'b0, 30'h0);
      if (arm_at_fall) bus.arm = 1'b1;
      step(1'b0, 1'b0, 1'b0, 30'h0);
      bus.arm = 1'b0;
      repeat (2) step(1'b0, 1'b0, 1'b0, 30'h0);
      idle(4);
   endtask

   function automatic bit cell_lit(input int mode, input int r, input int c);
      case (mode)
         M_SINGLE: return (r == 5 && c == 3);
         M_CHECK:  return ((r + c) % 2 == 0);
         M_ALL:    return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   // Dark frames carry noise everywhere except the sample pixel of each cell.
   function automatic logic [29:0] pix_rgb(input int x, input int y, input int mode);
      bit is_sample;
      is_sample = (x % CW == SX) && (y % CH == SY);
      case (mode)
         M_DARK:   return (!is_sample && (x + y) % 3 == 0) ? {10'h3FF, 20'h0} : 30'h0;
         M_SINGLE: return cell_lit(mode, y / CH, x / CW) ? 30'h3FFF_FFFF : 30'h0;
         M_CHECK:  return cell_lit(mode, y / CH, x / CW) ? {10'h0, 10'h200, 10'h0} : 30'h0;
         default:  return {20'h0, 10'h001};
      endcase
   endfunction

   task automatic line(input int y, input int mode, input int npix);
      logic [29:0] rgb;
      for (int x = 0; x < npix; x++) begin
         rgb = pix_rgb(x, y, mode);
         step(1'b0, 1'b1, 1'b1, rgb);
         step(1'b1, 1'b1, 1'b1, rgb);
      end
      repeat (2) begin
         step(1'b0, 1'b0, 1'b1, 30'h0);
         step(1'b1, 1'b0, 1'b1, 30'h0);
      end
   endtask

   task automatic frame_lines(input int mode, input int short_y);
      for (int y = 0; y < VA; y++) line(y, mode, (y == short_y) ? HA - 1 : HA);
   endtask

   function automatic logic [15:0] crc_model(input int mode);
      logic [15:0] c;
      bit          b;
      c = 16'hFFFF;
      for (int a = 0; a < 1024; a++) begin
         b = cell_lit(mode, a / 32, a % 32);
         if (c[15] ^ b) c = {c[14:0], 1'b0} ^ 16'h1021;
         else           c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   task automatic run_table(input int phase);
      for (int i = 0; i < 22; i++) begin
         if (vecs[i].phase == phase) begin
            bus.rd_addr = vecs[i].addr;
            idle(1);
            check($sformatf("rd_p%0d_%0h", phase, vecs[i].addr), bus.rd_data, vecs[i].exp);
         end
      end
   endtask

   initial begin
      vecs = '{
         '{1, 16'h02A3, 8'h01}, '{1, 16'h02A2, 8'h00}, '{1, 16'h02C3, 8'h00},
         '{1, 16'h0200, 8'h00}, '{1, 16'h05FF, 8'h00}, '{1, 16'h01FF, 8'h00},
         '{1, 16'h0600, 8'h00},
         '{2, 16'h0200, 8'h01}, '{2, 16'h0201, 8'h00}, '{2, 16'h0220, 8'h00},
         '{2, 16'h0221, 8'h01}, '{2, 16'h02A3, 8'h01}, '{2, 16'h05FE, 8'h00},
         '{2, 16'h05FF, 8'h01}, '{2, 16'h01FF, 8'h00}, '{2, 16'h0600, 8'h00},
         '{2, 16'hFFFF, 8'h00}, '{2, 16'h0000, 8'h00},
         '{3, 16'h0200, 8'h00}, '{3, 16'h0221, 8'h00}, '{3, 16'h02A3, 8'h00},
         '{3, 16'h05FF, 8'h00}
      };

      reset = 1'b1;
      VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK = 1'b0;
      VGA_R = '0; VGA_G = '0; VGA_B = '0;
      bus.arm = 1'b0;
      bus.rd_addr = 16'h0200;
      idle(4);
      check("reset_busy", bus.busy, 0);
      check("reset_frames", bus.frames, 0);
      check("reset_line_err", bus.line_err, 0);
      check("reset_frame_done", bus.frame_done, 0);
      check("reset_rd_data", bus.rd_data, 0);
      reset = 1'b0;
      idle(2);

      // Single lit cell at col 3, row 5.
      pulse_arm();
      idle(1);
      check("armed_busy", bus.busy, 1);
      vs_pulse(1'b0);
      frame_lines(M_SINGLE, -1);
      vs_pulse(1'b0);
      idle(4);
      check("single_fd_count", fd_count, 1);
      check("single_frames", bus.frames, 1);
      check("single_busy", bus.busy, 0);
      check("single_line_err", bus.line_err, 0);
`ifdef VGA_CAPTURE_CRC_EN
      check("single_crc", bus.frame_crc, crc_model(M_SINGLE));
`endif
      run_table(1);

      // Arm coincident with a VS fall waits one frame; re-arm during capture is ignored.
      vs_pulse(1'b1);
      check("coinc_armed_busy", bus.busy, 1);
      frame_lines(M_ALL, -1);
      vs_pulse(1'b0);
      idle(2);
      check("coinc_no_fd", fd_count, 1);
      check("capture_busy", bus.busy, 1);
      pulse_arm();
      frame_lines(M_CHECK, -1);
      vs_pulse(1'b0);
      idle(4);
      check("check_fd_count", fd_count, 2);
      check("check_frames", bus.frames, 2);
      check("check_busy", bus.busy, 0);
`ifdef VGA_CAPTURE_CRC_EN
      check("check_crc", bus.frame_crc, crc_model(M_CHECK));
`endif
      run_table(2);

      // Reset part-way through a capture.
      bus.rd_addr = 16'h05FF;
      pulse_arm();
      vs_pulse(1'b0);
      for (int y = 0; y < 40; y++) line(y, M_DARK, HA);
      check("mid_rd_before", bus.rd_data, 8'h01);
      step(1'b0, 1'b0, 1'b1, 30'h0);
      reset = 1'b1;
      idle(1);
      check("mid_reset_busy", bus.busy, 0);
      check("mid_reset_rd", bus.rd_data, 8'h00);
      check("mid_reset_frames", bus.frames, 0);
      reset = 1'b0;
      idle(1);
      check("mid_rd_kept", bus.rd_data, 8'h01);
      for (int y = 40; y < VA; y++) line(y, M_DARK, HA);
      vs_pulse(1'b0);
      idle(4);
      check("mid_no_fd", fd_count, 2);
      check("mid_frames", bus.frames, 0);
      check("mid_busy", bus.busy, 0);

      // Short line on an otherwise dark frame.
      pulse_arm();
      vs_pulse(1'b0);
      frame_lines(M_DARK, 10);
      vs_pulse(1'b0);
      idle(4);
      check("short_line_err", bus.line_err, 1);
      check("short_fd_count", fd_count, 3);
      check("short_frames", bus.frames, 1);
      check("short_busy", bus.busy, 0);
`ifdef VGA_CAPTURE_CRC_EN
      check("dark_crc", bus.frame_crc, crc_model(M_DARK));
`endif
      run_table(3);
      pulse_arm();
      check("rearm_clears_err", bus.line_err, 0);
      check("rearm_busy", bus.busy, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_capture.md
# vga_capture

Monitor that sits on the VGA output pins of `mmio_vga` and reconstructs the 32x32 character-cell screen from the raster. It samples the centre pixel of every cell into a 1024-entry capture memory that a bench or CPU-side master reads back at the same addresses the screen memory is written at (0x200–0x5FF). It is the read-side counterpart of the MMIO screen writer and is used to check framebuffer-to-pixel correctness end to end.

## Interface
- `BASE_ADDR`, 16'h200: first byte address of the capture window; the window spans 1024 bytes.
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `CLOCK_50  in  1`: system clock; all logic runs on its rising edge.
- `reset  in  1`: reset, synchronous, active-high.
- `VGA_CLK  in  1`: pixel clock from the driver. Treated as data and edge-detected; it is never used as a clock.
- `VGA_HS`, `VGA_VS`  in  1: syncs, active-low.
- `VGA_BLANK  in  1`: active-high display enable (low = blanked).
- `VGA_R`, `VGA_G`, `VGA_B`  in  10: DAC colour inputs.
- `arm  in  1`: single-cycle pulse that requests capture of the next full frame.
- `rd_addr  in  16`: readback address.
- `rd_data  out  8`: 8'h01 if the cell is lit, else 8'h00.
- `busy  out  1`: high in ARMED and CAPTURE.
- `frame_done  out  1`: one-cycle pulse when a capture completes.
- `frames  out  16`: count of completed captures; wraps at 0xFFFF to 0.
- `line_err  out  1`: sticky raster-geometry error flag.
- `frame_crc  out  16`: present only when `VGA_CAPTURE_CRC_EN` is defined.

## Operation
- **Pixel strobe:** `pix` is asserted in the cycle where `VGA_CLK` = 1 and its registered previous value = 0. All raster logic advances only on `pix`.
- **Horizontal counters:** `cx` (0..19) and `col` (0..31) advance on `pix` while `VGA_BLANK` = 1. They clear on the falling edge of `VGA_BLANK`.
- **Vertical counters:** `cy` (0..14) and `row` (0..31) advance at each falling edge of `VGA_BLANK`. They clear on the falling edge of `VGA_VS`.
- **Sampling:** when `pix` && `VGA_BLANK` && `cx`==10 && `cy`==7, write lit = (R|G|B != 0) to cell address `row*32+col`.
- **FSM states:**
  - IDLE: on `arm`, go to ARMED and clear `line_err`.
  - ARMED: on a `VGA_VS` falling edge, go to CAPTURE.
  - CAPTURE: on the next `VGA_VS` falling edge, go to IDLE, pulse `frame_done`, and increment `frames`.
  - RAM writes are enabled only in CAPTURE.
- **Geometry check** (CAPTURE only):
  - At each `VGA_BLANK` fall, the active pixel count must equal `H_ACTIVE`.
  - At frame end, the active line count must equal `V_ACTIVE`.
  - Any mismatch sets `line_err`. The capture still completes.
- **Counter saturation:** the pixel and line counters are 10 bits and saturate at 1023. Cell counters do not advance past 31.
- **Readback:** an address in [BASE_ADDR, BASE_ADDR+1023] reads cell `rd_addr - BASE_ADDR`. Any other address returns 8'h00. Reads are legal in any state and return the currently stored value.
- **Arm while busy:** ignored.
- **Arm coincident with a VS fall in IDLE:** the FSM enters ARMED and waits for the following VS fall.
- **Reset:**
  - FSM returns to IDLE; all counters clear; `frames`=0, `line_err`=0, `busy`=0, `frame_done`=0, `rd_data`=0.
  - RAM contents are not cleared.
  - A reset mid-capture produces no `frame_done`.

## Timing
- RAM write lands 1 cycle after the sampling `pix`.
- `rd_data` is registered and valid 1 cycle after `rd_addr`.
- `frame_done` asserts in the cycle after the terminating VS fall is detected. `frames` updates in the same cycle.
- Sync and blank edges are detected against registered copies, so every edge decision lags its pin by 1 cycle.

## Configuration
- **`VGA_CAPTURE_CRC_EN` defined:**
  - CRC-16-CCITT (poly 0x1021, MSB-first) is computed over each lit bit in write order, which is ascending cell address.
  - The CRC is initialised to 0xFFFF on entry to CAPTURE.
  - `frame_crc` is latched on `frame_done`. Its reset value is 0x0000.
- **Not defined:** the `frame_crc` port and all CRC logic are absent.

## Structure
- **`vga_capture_pkg`:** `H_ACTIVE`, `V_ACTIVE`, `CELL_W`=20, `CELL_H`=15, `GRID`=32, `SAMPLE_X`=10, `SAMPLE_Y`=7, `CRC_POLY`, `CRC_INIT`, and the FSM state enum {IDLE, ARMED, CAPTURE}.
- **Sub-module `capture_ram`:** 1024x1 simple dual-port memory (1 write port, 1 registered read port), both ports on `CLOCK_50`.

## Test plan
- **Reset:** assert reset -> `busy`=0, `frames`=0, `line_err`=0, `frame_done` never pulses, `rd_data`=8'h00.
- **Single lit cell:** `arm`, then drive a 640x480 synthetic raster (VGA_CLK = CLOCK_50/2) with only cell (col 3, row 5) white -> exactly one `frame_done`, `frames`=1; `rd_addr`=0x2A3 gives 8'h01, and 0x2A2, 0x2C3, 0x200, 0x5FF give 8'h00.
- **Arm while busy:** `arm` again during CAPTURE -> ignored; exactly one `frame_done` for two frames of raster.
- **Short line:** one line of 639 active pixels -> `line_err`=1 after the frame and `frame_done` still pulses; the next `arm` clears `line_err`.
- **Reset mid-capture:** reset at line 200 -> `busy`=0 next cycle, no `frame_done`, `frames` unchanged at 0.
- **CRC (macro defined):** all-dark frame -> `frame_crc` equals the CCITT of 1024 zero bits from init 0xFFFF (bench model value); checkerboard frame -> matches bench model.
